// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants and anode helper for the seven-segment scan path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int   SEG_NIBBLE_W = 4;
    localparam int   MAX_DIGITS   = 8;
    localparam logic ANODE_OFF    = 1'b1;

    // Active-low anode vector with only the selected digit driven on.
    function automatic logic [MAX_DIGITS-1:0] anode_onecold(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v = {MAX_DIGITS{ANODE_OFF}};
        v[idx] = ~ANODE_OFF;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
// ============================================================================
// Module   : scan_tick_gen
// Purpose  : Free-running CLK_DIV prescaler; tick marks the last cycle of a slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == C_CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Double-buffered hex display scanner sharing one segment decoder.
//            Optional leading-zero suppression when SEG_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SEG_NIBBLE_W*DIGITS-1:0] value_in,
    input  logic                         load,
    output logic                         ready,
    input  logic [DIGITS-1:0]            blank_mask,
    output logic [SEG_NIBBLE_W-1:0]      dec_nibble,
    output logic [DIGITS-1:0]            an,
    output logic                         frame_done
);

    localparam int               VAL_W      = SEG_NIBBLE_W * DIGITS;
    localparam int               IDX_W      = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);

    logic [IDX_W-1:0]        r_idx;
    logic [VAL_W-1:0]        r_disp;
    logic [VAL_W-1:0]        r_pend;
    logic                    r_pend_v;
    logic [DIGITS-1:0]       r_an;
    logic [SEG_NIBBLE_W-1:0] r_nib;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_accept;
    logic [IDX_W-1:0]        w_idx_next;
    logic [VAL_W-1:0]        w_disp_next;
    logic [SEG_NIBBLE_W-1:0] w_nib_next;
    logic [DIGITS-1:0]       w_onecold;
    logic [DIGITS-1:0]       w_lzb;
    logic [DIGITS-1:0]       w_dark;

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign ready    = ~r_pend_v;
    assign w_wrap   = w_tick && (r_idx == C_IDX_LAST);
    assign w_accept = load && ready;

    always_comb begin
        w_idx_next  = r_idx;
        w_disp_next = r_disp;
        w_nib_next  = '0;
        if (w_tick) begin
            w_idx_next = (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
        // A load landing on the wrap edge skips the pending buffer entirely.
        if (w_wrap) begin
            if (w_accept) begin
                w_disp_next = value_in;
            end else if (r_pend_v) begin
                w_disp_next = r_pend;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_next == IDX_W'(i)) begin
                w_nib_next = w_disp_next[i*SEG_NIBBLE_W +: SEG_NIBBLE_W];
            end
        end
    end

    assign w_onecold = DIGITS'(anode_onecold(3'(w_idx_next)));

`ifdef SEG_LZB_EN
    for (genvar i = 0; i < DIGITS; i++) begin : g_lzb
        if (i == 0) begin : g_lzb_d0
            assign w_lzb[i] = 1'b0;
        end else begin : g_lzb_dn
            assign w_lzb[i] = (w_disp_next[VAL_W-1:i*SEG_NIBBLE_W] == '0);
        end
    end
`else
    assign w_lzb = '0;
`endif

    assign w_dark = blank_mask | w_lzb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= C_IDX_LAST;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_v     <= 1'b0;
            r_an         <= {DIGITS{ANODE_OFF}};
            r_nib        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_idx        <= w_idx_next;
            r_disp       <= w_disp_next;
            r_frame_done <= w_wrap;
            if (w_accept && !w_wrap) begin
                r_pend   <= value_in;
                r_pend_v <= 1'b1;
            end else if (w_wrap) begin
                r_pend_v <= 1'b0;
            end
            if (w_tick) begin
                r_an  <= w_dark[w_idx_next] ? {DIGITS{ANODE_OFF}} : w_onecold;
                r_nib <= w_nib_next;
            end
        end
    end

    assign an         = r_an;
    assign dec_nibble = r_nib;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Scoreboard bench for seg_scan_ctrl with DIGITS=4, CLK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    typedef struct {
        logic [3:0] an;
        logic [3:0] nib;
        logic       fd;
        logic       rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        ready;
    logic [3:0]  blank_mask;
    logic [3:0]  dec_nibble;
    logic [3:0]  an;
    logic        frame_done;

    int   n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    seg_scan_ctrl #(
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .ready      (ready),
        .blank_mask (blank_mask),
        .dec_nibble (dec_nibble),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Bench-side count of clock edges since reset release; slots start every CLK_DIV edges.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    always @(negedge clk) begin
        if (!rst && n > 0) begin
            if (n % CLK_DIV == 0) begin
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if ({an, dec_nibble, frame_done, ready} !== {e.an, e.nib, e.fd, e.rdy}) begin
                        failures++;
                        $display("FAIL slot@%0d: got an=%b nib=%h fd=%b rdy=%b, want an=%b nib=%h fd=%b rdy=%b",
                                 n, an, dec_nibble, frame_done, ready, e.an, e.nib, e.fd, e.rdy);
                    end
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_done_idle@%0d: got %b want 0", n, frame_done);
                end
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] nb, input logic f, input logic r);
        exp_t e;
        e.an = a; e.nib = nb; e.fd = f; e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic at_edge(input int e);
        int g;
        g = 0;
        while (n != e && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (n != e) begin
            checks++;
            failures++;
            $display("FAIL at_edge_timeout: got %0d want %0d", n, e);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
        $finish;
    end

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        value_in   = '0;
        blank_mask = '0;
        #3;
        check("reset_an",    {4'h0, an},         8'h0F);
        check("reset_nib",   {4'h0, dec_nibble}, 8'h00);
        check("reset_ready", {7'h0, ready},      8'h01);
        check("reset_fd",    {7'h0, frame_done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Phase 1: load, ignored reload, bypass load, blanking.
        push(4'b1110, 4'h0, 1'b1, 1'b1);
`ifdef SEG_LZB_EN
        push(4'b1111, 4'h0, 1'b0, 1'b0);
        push(4'b1111, 4'h0, 1'b0, 1'b0);
        push(4'b1111, 4'h0, 1'b0, 1'b0);
`else
        push(4'b1101, 4'h0, 1'b0, 1'b0);
        push(4'b1011, 4'h0, 1'b0, 1'b0);
        push(4'b0111, 4'h0, 1'b0, 1'b0);
`endif
        push(4'b1110, 4'h4, 1'b1, 1'b1);
        push(4'b1101, 4'h3, 1'b0, 1'b1);
        push(4'b1011, 4'h2, 1'b0, 1'b1);
        push(4'b0111, 4'h1, 1'b0, 1'b1);
        push(4'b1110, 4'h0, 1'b1, 1'b1);
        push(4'b1101, 4'hC, 1'b0, 1'b0);
        push(4'b1011, 4'h5, 1'b0, 1'b0);
        push(4'b0111, 4'hA, 1'b0, 1'b0);
        push(4'b1110, 4'h4, 1'b1, 1'b1);
        push(4'b1111, 4'h3, 1'b0, 1'b1);
        push(4'b1011, 4'h2, 1'b0, 1'b1);
        push(4'b0111, 4'h1, 1'b0, 1'b1);
        push(4'b1110, 4'h4, 1'b1, 1'b1);

        at_edge(5);  load = 1'b1; value_in = 16'h1234;
        at_edge(6);  value_in = 16'hBEEF;
        at_edge(10); load = 1'b0;
        at_edge(35); load = 1'b1; value_in = 16'hA5C0;
        at_edge(36); check("bypass_ready", {7'h0, ready}, 8'h01);
                     value_in = 16'h1234;
        at_edge(37); load = 1'b0;
        at_edge(44); blank_mask = 4'b0010;
        at_edge(60); blank_mask = 4'b0000;

        // Reset in the middle of a frame while a value is pending.
        at_edge(69); load = 1'b1; value_in = 16'h5678;
        at_edge(70); load = 1'b0;
        at_edge(71); check("pending_ready", {7'h0, ready}, 8'h00);
        at_edge(73);
        #2 rst = 1'b1;
        #1;
        check("midrst_an",    {4'h0, an},         8'h0F);
        check("midrst_nib",   {4'h0, dec_nibble}, 8'h00);
        check("midrst_ready", {7'h0, ready},      8'h01);
        check("midrst_fd",    {7'h0, frame_done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        check("release_ready", {7'h0, ready}, 8'h01);

        // Phase 2: discarded pending value, then 0x0050 and 0x0000.
        for (int k = 1; k <= 16; k++) begin
            int          d;
            logic [15:0] v;
            logic [15:0] sh;
            logic        dark;
            d    = (k - 1) % 4;
            v    = (k >= 9 && k <= 12) ? 16'h0050 : 16'h0000;
            sh   = v >> (4 * d);
            dark = 1'b0;
`ifdef SEG_LZB_EN
            dark = (d > 0) && (sh == 16'h0);
`endif
            push(dark ? 4'b1111 : ~(4'b0001 << d), sh[3:0], d == 0,
                 (k <= 5) || (k == 9) || (k >= 13));
        end
        at_edge(21); load = 1'b1; value_in = 16'h0050;
        at_edge(22); load = 1'b0;
        at_edge(37); load = 1'b1; value_in = 16'h0000;
        at_edge(38); load = 1'b0;
        at_edge(66);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
